edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event controller. Synchronises N_CH async inputs and detects edges per channel under per-channel mode config.

---
 rtl/edge_evt_pkg.sv | 34 +++
 rtl/edge_sync_detect.sv | 50 +++++
 rtl/edge_event_arbiter.sv | 155 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
//------------------------------------------------------------------------------
// Module      : edge_evt_pkg
// Description : Shared encodings for the edge-event arbiter (modes, event
//               types, FSM states) plus mode-qualification helpers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  function automatic logic mode_allows_rise(input logic [1:0] mode);
    return (mode == MODE_RISE) || (mode == MODE_BOTH);
  endfunction

  function automatic logic mode_allows_fall(input logic [1:0] mode);
    return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_sync_detect.sv
//------------------------------------------------------------------------------
// Module      : edge_sync_detect
// Description : Per-channel synchroniser, previous-value flop and
//               mode-qualified registered edge detection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_sync_detect
  import edge_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  output logic       det_rise,
  output logic       det_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_det_rise;
  logic                   r_det_fall;
  logic                   w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  // prev follows the synchronised level even when the channel is OFF
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_det_rise <= 1'b0;
      r_det_fall <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], sig};
      r_prev     <= w_last;
      r_det_rise <= w_last & ~r_prev & mode_allows_rise(mode);
      r_det_fall <= ~w_last & r_prev & mode_allows_fall(mode);
    end
  end

  assign det_rise = r_det_rise;
  assign det_fall = r_det_fall;

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
//------------------------------------------------------------------------------
// Module      : edge_event_arbiter
// Description : Multi-channel edge-event controller with one pending slot per
//               channel and a round-robin valid/ready event port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int IDW         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_in,
  input  logic            mode_we,
  input  logic [IDW-1:0]  mode_ch,
  input  logic [1:0]      mode_val,
  output logic            evt_valid,
  output logic [IDW-1:0]  evt_ch,
  output logic            evt_type,
  input  logic            evt_ready,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overflow,
  input  logic            ovf_clr
);

  logic [1:0]      r_mode [N_CH];
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_type;
  logic [N_CH-1:0] r_overflow;
  state_t          r_state;
  logic            r_evt_valid;
  logic [IDW-1:0]  r_evt_ch;
  logic            r_evt_type;
  logic [IDW-1:0]  r_rr_ptr;

  logic [N_CH-1:0] w_det_rise;
  logic [N_CH-1:0] w_det_fall;
  logic [N_CH-1:0] w_det;
  logic [N_CH-1:0] w_xfer_ch;
  logic [N_CH-1:0] w_ovf_set;
  logic [N_CH-1:0] w_accept;
  logic            w_xfer;
  logic            w_pick_found;
  logic [IDW-1:0]  w_pick_ch;
  int              w_idx;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      edge_sync_detect #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_det (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig_in[gi]),
        .mode     (r_mode[gi]),
        .det_rise (w_det_rise[gi]),
        .det_fall (w_det_fall[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) r_mode[i] <= MODE_OFF;
    end else if (mode_we && (int'(mode_ch) < N_CH)) begin
      r_mode[mode_ch] <= mode_val;
    end
  end

  assign w_det  = w_det_rise | w_det_fall;
  assign w_xfer = r_evt_valid & evt_ready;

  always_comb begin
    w_xfer_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_xfer_ch[i] = w_xfer && (int'(r_evt_ch) == i);
    end
  end

  // A transfer frees the slot in the same cycle, so a coincident edge is kept
  assign w_ovf_set = w_det & r_pending & ~w_xfer_ch;
  assign w_accept  = w_det & ~w_ovf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= '0;
      r_type     <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= w_accept | (r_pending & ~w_xfer_ch);
      r_type     <= (w_accept & w_det_rise) | (r_type & ~w_accept);
      r_overflow <= w_ovf_set | (r_overflow & ~{N_CH{ovf_clr}});
    end
  end

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_ch    = '0;
    w_idx        = 0;
    for (int j = 0; j < N_CH; j++) begin
      w_idx = int'(r_rr_ptr) + j;
      if (w_idx >= N_CH) w_idx = w_idx - N_CH;
      if (!w_pick_found && r_pending[w_idx]) begin
        w_pick_found = 1'b1;
        w_pick_ch    = IDW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_type  <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_evt_ch    <= w_pick_ch;
            r_evt_type  <= r_type[w_pick_ch];
            r_evt_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            r_evt_valid <= 1'b0;
            r_state     <= ST_IDLE;
            r_rr_ptr    <= (r_evt_ch == IDW'(N_CH - 1)) ? '0 : r_evt_ch + IDW'(1);
          end
        end
        default: begin
          r_evt_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign evt_type  = r_evt_type;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_edge_event_arbiter
// Description : Directed self-checking bench for edge_event_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] sig_in;
  logic       mode_we;
  logic [1:0] mode_ch;
  logic [1:0] mode_val;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_type;
  logic       evt_ready;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  logic seen_valid;

  edge_event_arbiter #(
    .N_CH        (4),
    .IDW         (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .mode_we   (mode_we),
    .mode_ch   (mode_ch),
    .mode_val  (mode_val),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_type  (evt_type),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grant(input string tag, input logic [1:0] ch, input logic typ);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_ch"},    32'(evt_ch),    32'(ch));
    chk({tag, "_type"},  32'(evt_type),  32'(typ));
  endtask

  task automatic write_mode(input logic [1:0] ch, input logic [1:0] val);
    mode_we  = 1'b1;
    mode_ch  = ch;
    mode_val = val;
    tick(1);
    mode_we  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sig_in = 4'hF; mode_we = 1'b0; mode_ch = 2'd0; mode_val = 2'd0;
    evt_ready = 1'b0; ovf_clr = 1'b0;

    // reset state and quiet operation with all channels OFF
    #3;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_type", 32'(evt_type), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen_valid = seen_valid | evt_valid;
    end
    chk("off_no_evt", 32'(seen_valid), 32'd0);
    sig_in = 4'h0;
    tick(5);
    chk("off_no_pending", 32'(pending), 32'd0);

    // single rising event on ch0, exact latency
    write_mode(2'd0, 2'b01);
    evt_ready = 1'b1;
    sig_in[0] = 1'b1;
    tick(4);
    chk("lat_pending_k3", 32'(pending), 32'h1);
    chk("lat_valid_k3", 32'(evt_valid), 32'd0);
    tick(1);
    grant("lat_k4", 2'd0, 1'b1);
    tick(1);
    chk("lat_valid_k5", 32'(evt_valid), 32'd0);
    chk("lat_pending_k5", 32'(pending), 32'h0);
    sig_in[0] = 1'b0;
    tick(6);
    chk("rise_only_ignores_fall", 32'(pending), 32'h0);

    // both-edge mode on ch1
    write_mode(2'd1, 2'b11);
    sig_in[1] = 1'b1;
    tick(5);
    grant("both_rise", 2'd1, 1'b1);
    tick(5);
    sig_in[1] = 1'b0;
    tick(5);
    grant("both_fall", 2'd1, 1'b0);
    tick(1);
    chk("both_pending", 32'(pending), 32'h0);
    chk("both_overflow", 32'(overflow), 32'h0);

    // simultaneous edges, rr_ptr = 2 after the ch1 grant
    write_mode(2'd0, 2'b01);
    write_mode(2'd1, 2'b01);
    write_mode(2'd2, 2'b01);
    write_mode(2'd3, 2'b01);
    sig_in = 4'hF;
    tick(5);
    grant("rr2_a", 2'd2, 1'b1);
    tick(1);
    chk("rr2_gap", 32'(evt_valid), 32'd0);
    tick(1);
    grant("rr2_b", 2'd3, 1'b1);
    tick(2);
    grant("rr2_c", 2'd0, 1'b1);
    tick(2);
    grant("rr2_d", 2'd1, 1'b1);
    tick(1);
    chk("rr2_done", 32'(pending), 32'h0);

    // move rr_ptr to 0 via a ch3 grant, then all four again
    sig_in = 4'h0;
    tick(5);
    chk("rr_fall_ignored", 32'(pending), 32'h0);
    sig_in = 4'h8;
    tick(5);
    grant("rr_ch3", 2'd3, 1'b1);
    tick(1);
    sig_in = 4'h0;
    tick(5);
    sig_in = 4'hF;
    tick(5);
    grant("rr0_a", 2'd0, 1'b1);
    tick(2);
    grant("rr0_b", 2'd1, 1'b1);
    tick(2);
    grant("rr0_c", 2'd2, 1'b1);
    tick(2);
    grant("rr0_d", 2'd3, 1'b1);
    tick(1);

    // overflow on ch2 while its event is held
    sig_in = 4'h0;
    tick(5);
    write_mode(2'd2, 2'b11);
    evt_ready = 1'b0;
    sig_in[2] = 1'b1;
    tick(5);
    grant("ovf_offer", 2'd2, 1'b1);
    sig_in[2] = 1'b0;
    tick(4);
    chk("ovf_set", 32'(overflow), 32'h4);
    grant("ovf_kept", 2'd2, 1'b1);
    chk("ovf_pending", 32'(pending), 32'h4);
    evt_ready = 1'b1;
    tick(1);
    chk("ovf_xfer_valid", 32'(evt_valid), 32'd0);
    chk("ovf_xfer_pending", 32'(pending), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h4);
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      seen_valid = seen_valid | evt_valid;
    end
    chk("ovf_single_xfer", 32'(seen_valid), 32'd0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'h0);

    // edge on the channel transferring in the same cycle
    evt_ready = 1'b0;
    sig_in[2] = 1'b1;
    tick(5);
    grant("same_offer", 2'd2, 1'b1);
    sig_in[2] = 1'b0;
    tick(3);
    evt_ready = 1'b1;
    tick(1);
    chk("same_valid", 32'(evt_valid), 32'd0);
    chk("same_pending", 32'(pending), 32'h4);
    chk("same_overflow", 32'(overflow), 32'h0);
    tick(1);
    grant("same_new", 2'd2, 1'b0);
    tick(1);

    // asynchronous reset in OFFER
    evt_ready = 1'b0;
    sig_in[2] = 1'b1;
    tick(5);
    grant("arst_offer", 2'd2, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_pending", 32'(pending), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    evt_ready = 1'b1;
    tick(3);
    sig_in[2] = 1'b0;
    tick(3);
    sig_in[2] = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen_valid = seen_valid | evt_valid;
    end
    chk("arst_modes_off", 32'(seen_valid), 32'd0);
    write_mode(2'd2, 2'b11);
    sig_in[2] = 1'b0;
    tick(5);
    grant("arst_reconf", 2'd2, 1'b0);
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
